// File: rtl/digit_scan_if.sv
// digit_scan_if
// Bundles the display-side signals of the digit scan controller.
//   master : value producer / bench side (drives en, digits, dp_in, digit_en)
//   slave  : digit_scan_ctrl side (drives an, seg, dp, sel, frame_done, state)
// Signals:
//   en         scan enable, 1 = scanning, 0 = display dark
//   digits     four hex nibbles, digit i = digits[4i+3:4i]
//   dp_in      decimal point request per digit, 1 = lit
//   digit_en   per-digit enable mask, 1 = digit takes part in the scan
//   an         anodes, active-low
//   seg        segments {g,f,e,d,c,b,a}, active-low
//   dp         decimal point, active-low
//   sel        index of the current/last scanned digit
//   frame_done 1-cycle pulse when the scan wraps
//   state      debug view of the scan FSM (0 IDLE, 1 BLANK, 2 SHOW)
// Handshake: there is no valid/ready pair; inputs are level signals sampled on
// every rising clk edge, and all outputs are registered and change only on it.
interface digit_scan_if;
    logic        en;
    logic [15:0] digits;
    logic [3:0]  dp_in;
    logic [3:0]  digit_en;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic [1:0]  sel;
    logic        frame_done;
    logic [1:0]  state;

    modport master (
        output en, digits, dp_in, digit_en,
        input  an, seg, dp, sel, frame_done, state
    );

    modport slave (
        input  en, digits, dp_in, digit_en,
        output an, seg, dp, sel, frame_done, state
    );
endinterface

// File: rtl/digit_scan_ctrl.sv
// digit_scan_ctrl
// Scan scheduler for a 4-digit seven-segment display sharing one segment bus.
// Each digit gets BLANK_CYC cycles with all anodes off (anti-ghosting) followed
// by DIV_MAX+1 cycles lit. The hex nibble, decimal point and (optionally) the
// leading-zero decision are snapshotted on SHOW entry, so input changes only
// appear at the next digit.
// Ports:
//   clk  rising-edge system clock
//   rst  synchronous reset, active-low
//   bus  digit_scan_if.slave (en/digits/dp_in/digit_en in; an/seg/dp/sel/
//        frame_done/state out, all registered)
// Parameters:
//   DIV_MAX    SHOW phase lasts DIV_MAX+1 cycles
//   BLANK_CYC  blank cycles before each digit, must be >= 1
// Build option:
//   LEADING_ZERO_BLANK_EN  when defined, digit i>0 is kept dark if every nibble
//                          at index >= i is zero; timing is unaffected.
module digit_scan_ctrl #(
    parameter int DIV_MAX   = 99_999,
    parameter int BLANK_CYC = 500
) (
    input logic         clk,
    input logic         rst,
    digit_scan_if.slave bus
);
    localparam int PW = (DIV_MAX > 0) ? $clog2(DIV_MAX + 1) : 1;
    localparam int BW = $clog2(BLANK_CYC + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      sel_q, sel_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [BW-1:0]   blank_q, blank_d;
    logic [3:0]      an_q, an_d;
    logic [6:0]      seg_q, seg_d;
    logic            dp_q, dp_d;
    logic            fd_q, fd_d;

    // Scratch values for the combinational block.
    logic [1:0]      next_sel;
    logic [1:0]      low_sel;
    logic [1:0]      idx;
    logic            suppress;

    function automatic logic [6:0] seg_decode(input logic [3:0] n);
        case (n)
            4'h0:    seg_decode = 7'b1000000;
            4'h1:    seg_decode = 7'b1111001;
            4'h2:    seg_decode = 7'b0100100;
            4'h3:    seg_decode = 7'b0110000;
            4'h4:    seg_decode = 7'b0011001;
            4'h5:    seg_decode = 7'b0010010;
            4'h6:    seg_decode = 7'b0000010;
            4'h7:    seg_decode = 7'b1111000;
            4'h8:    seg_decode = 7'b0000000;
            4'h9:    seg_decode = 7'b0010000;
            4'hA:    seg_decode = 7'b0001000;
            4'hB:    seg_decode = 7'b0000011;
            4'hC:    seg_decode = 7'b1000110;
            4'hD:    seg_decode = 7'b0100001;
            4'hE:    seg_decode = 7'b0000110;
            default: seg_decode = 7'b0001110;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            sel_q   <= 2'd0;
            presc_q <= '0;
            blank_q <= '0;
            an_q    <= 4'b1111;
            seg_q   <= 7'b1111111;
            dp_q    <= 1'b1;
            fd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            presc_q <= presc_d;
            blank_q <= blank_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            fd_q    <= fd_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        presc_d  = presc_q;
        blank_d  = blank_q;
        an_d     = an_q;
        seg_d    = seg_q;
        dp_d     = dp_q;
        fd_d     = 1'b0;
        next_sel = sel_q;
        low_sel  = 2'd0;
        idx      = 2'd0;
        suppress = 1'b0;

        // First enabled digit after sel, cyclic; k=4 lands on sel itself and
        // is visited first so that any closer candidate overrides it.
        for (int k = 4; k >= 1; k--) begin
            idx = sel_q + 2'(k);
            if (bus.digit_en[idx]) next_sel = idx;
        end

        for (int i = 3; i >= 0; i--) begin
            if (bus.digit_en[i]) low_sel = 2'(i);
        end

`ifdef LEADING_ZERO_BLANK_EN
        suppress = (sel_q != 2'd0) && ((bus.digits >> {sel_q, 2'b00}) == 16'h0);
`endif

        if (!bus.en) begin
            // Dropping en abandons the current period immediately.
            state_d = IDLE;
            sel_d   = 2'd0;
            presc_d = '0;
            blank_d = '0;
            an_d    = 4'b1111;
            seg_d   = 7'b1111111;
            dp_d    = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = BLANK;
                    sel_d   = low_sel;
                    presc_d = '0;
                    blank_d = '0;
                    an_d    = 4'b1111;
                    seg_d   = 7'b1111111;
                    dp_d    = 1'b1;
                end
                BLANK: begin
                    if (blank_q == BW'(BLANK_CYC - 1)) begin
                        blank_d = '0;
                        if (bus.digit_en[sel_q]) begin
                            state_d = SHOW;
                            presc_d = '0;
                            if (!suppress) begin
                                an_d  = ~(4'b0001 << sel_q);
                                seg_d = seg_decode(bus.digits[{sel_q, 2'b00} +: 4]);
                                dp_d  = ~bus.dp_in[sel_q];
                            end
                        end
                    end else begin
                        blank_d = blank_q + BW'(1);
                    end
                end
                SHOW: begin
                    if (presc_q == PW'(DIV_MAX)) begin
                        state_d = BLANK;
                        presc_d = '0;
                        sel_d   = next_sel;
                        fd_d    = (next_sel <= sel_q);
                        an_d    = 4'b1111;
                        seg_d   = 7'b1111111;
                        dp_d    = 1'b1;
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    sel_d   = 2'd0;
                    presc_d = '0;
                    blank_d = '0;
                    an_d    = 4'b1111;
                    seg_d   = 7'b1111111;
                    dp_d    = 1'b1;
                end
            endcase
        end
    end

    assign bus.an         = an_q;
    assign bus.seg        = seg_q;
    assign bus.dp         = dp_q;
    assign bus.sel        = sel_q;
    assign bus.frame_done = fd_q;
    assign bus.state      = state_q;
endmodule

// File: tb/tb_digit_scan_ctrl.sv
// tb_digit_scan_ctrl
// Directed bench for digit_scan_ctrl with DIV_MAX=3, BLANK_CYC=2 (6-cycle
// digit period). Inputs change 1 ns after a rising edge; outputs are checked
// at that same point, well away from the next edge.
module tb_digit_scan_ctrl;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;
    int   n;
    int   lit;

    digit_scan_if bus ();

    digit_scan_ctrl #(
        .DIV_MAX   (3),
        .BLANK_CYC (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Blank cycles, then a 4-cycle lit window; returns at the first blank cycle
    // after the window.
    task automatic expect_digit(input int nb, input logic [3:0] e_an,
                                input logic [6:0] e_seg, input logic e_dp,
                                input logic [1:0] e_sel);
        for (int i = 0; i < nb; i++) begin
            check("blank_an", 32'(bus.an), 32'(4'hf));
            tick();
        end
        check("show_an", 32'(bus.an), 32'(e_an));
        check("show_seg", 32'(bus.seg), 32'(e_seg));
        check("show_dp", 32'(bus.dp), 32'(e_dp));
        check("show_sel", 32'(bus.sel), 32'(e_sel));
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_an", 32'(bus.an), 32'(e_an));
            check("hold_seg", 32'(bus.seg), 32'(e_seg));
        end
        tick();
    endtask

    task automatic wait_an(input logic [3:0] exp, input int max);
        int k;
        k = 0;
        while (bus.an !== exp && k < max) begin
            tick();
            k++;
        end
        check("wait_an", 32'(bus.an), 32'(exp));
    endtask

    task automatic fd_period(input int exp);
        int k;
        k = 0;
        do begin
            tick();
            k++;
        end while (bus.frame_done !== 1'b1 && k < 100);
        check("fd_period", 32'(k), 32'(exp));
    endtask

    initial begin
        n_cmp        = 0;
        n_err        = 0;
        rst          = 1'b0;
        bus.en       = 1'b0;
        bus.digits   = 16'h0000;
        bus.dp_in    = 4'b0000;
        bus.digit_en = 4'b0000;

        // Reset held for two cycles.
        tick();
        tick();
        check("rst_an", 32'(bus.an), 32'(4'hf));
        check("rst_seg", 32'(bus.seg), 32'(7'h7f));
        check("rst_dp", 32'(bus.dp), 32'(1'b1));
        check("rst_sel", 32'(bus.sel), 32'(2'd0));
        check("rst_fd", 32'(bus.frame_done), 32'(1'b0));
        check("rst_state", 32'(bus.state), 32'(2'd0));
        rst = 1'b1;

        // Full scan of 1234, dp on digit 1.
        bus.en       = 1'b1;
        bus.digit_en = 4'b1111;
        bus.digits   = 16'h1234;
        bus.dp_in    = 4'b0010;
        expect_digit(3, 4'b1110, 7'b0011001, 1'b1, 2'd0);
        check("scan_fd0", 32'(bus.frame_done), 32'(1'b0));
        check("scan_sel1", 32'(bus.sel), 32'(2'd1));
        expect_digit(2, 4'b1101, 7'b0110000, 1'b0, 2'd1);
        expect_digit(2, 4'b1011, 7'b0100100, 1'b1, 2'd2);
        expect_digit(2, 4'b0111, 7'b1111001, 1'b1, 2'd3);
        check("wrap_fd", 32'(bus.frame_done), 32'(1'b1));
        check("wrap_sel", 32'(bus.sel), 32'(2'd0));
        fd_period(24);

        // en drop in the middle of digit 2.
        expect_digit(2, 4'b1110, 7'b0011001, 1'b1, 2'd0);
        expect_digit(2, 4'b1101, 7'b0110000, 1'b0, 2'd1);
        tick();
        tick();
        check("d2_an", 32'(bus.an), 32'(4'b1011));
        tick();
        bus.en = 1'b0;
        tick();
        check("drop_an", 32'(bus.an), 32'(4'hf));
        check("drop_seg", 32'(bus.seg), 32'(7'h7f));
        check("drop_sel", 32'(bus.sel), 32'(2'd0));
        check("drop_state", 32'(bus.state), 32'(2'd0));

        // Re-assert with mask 0101: only digits 0 and 2.
        bus.en       = 1'b1;
        bus.digit_en = 4'b0101;
        expect_digit(3, 4'b1110, 7'b0011001, 1'b1, 2'd0);
        check("mask_sel2", 32'(bus.sel), 32'(2'd2));
        check("mask_fd0", 32'(bus.frame_done), 32'(1'b0));
        expect_digit(2, 4'b1011, 7'b0100100, 1'b1, 2'd2);
        check("mask_fd", 32'(bus.frame_done), 32'(1'b1));
        check("mask_sel0", 32'(bus.sel), 32'(2'd0));
        fd_period(12);

        // Empty mask: stays dark with sel frozen at 2.
        expect_digit(2, 4'b1110, 7'b0011001, 1'b1, 2'd0);
        bus.digit_en = 4'b0000;
        lit = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.an !== 4'hf) lit++;
            tick();
        end
        check("empty_lit", 32'(lit), 32'd0);
        check("empty_sel", 32'(bus.sel), 32'(2'd2));

        // Reset during digit 3, scan restarts at digit 0.
        bus.digit_en = 4'b1111;
        wait_an(4'b0111, 40);
        tick();
        rst = 1'b0;
        tick();
        check("mrst_an", 32'(bus.an), 32'(4'hf));
        check("mrst_seg", 32'(bus.seg), 32'(7'h7f));
        check("mrst_dp", 32'(bus.dp), 32'(1'b1));
        check("mrst_sel", 32'(bus.sel), 32'(2'd0));
        check("mrst_fd", 32'(bus.frame_done), 32'(1'b0));
        check("mrst_state", 32'(bus.state), 32'(2'd0));
        rst = 1'b1;
        expect_digit(3, 4'b1110, 7'b0011001, 1'b1, 2'd0);

        // Leading zeros: 0042 then 0000, snapshot taken at each SHOW entry.
        bus.digits = 16'h0042;
        expect_digit(2, 4'b1101, 7'b0011001, 1'b0, 2'd1);
`ifdef LEADING_ZERO_BLANK_EN
        expect_digit(2, 4'b1111, 7'b1111111, 1'b1, 2'd2);
        bus.digits = 16'h0000;
        expect_digit(2, 4'b1111, 7'b1111111, 1'b1, 2'd3);
        check("lz_fd", 32'(bus.frame_done), 32'(1'b1));
        expect_digit(2, 4'b1110, 7'b1000000, 1'b1, 2'd0);
        expect_digit(2, 4'b1111, 7'b1111111, 1'b1, 2'd1);
`else
        expect_digit(2, 4'b1011, 7'b1000000, 1'b1, 2'd2);
        bus.digits = 16'h0000;
        expect_digit(2, 4'b0111, 7'b1000000, 1'b1, 2'd3);
        check("lz_fd", 32'(bus.frame_done), 32'(1'b1));
        expect_digit(2, 4'b1110, 7'b1000000, 1'b1, 2'd0);
        expect_digit(2, 4'b1101, 7'b1000000, 1'b0, 2'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
